fec_tx_sched: RTL

Two-requester transmit scheduler for the rate-1/2 convolutional encoder (`fec`, 48-bit in, 96-bit out).
- Arbitrates between two 48-bit word sources with round-robin, using a valid/ready handshake.
- Presents the granted word to the encoder, captures the 96-bit codeword and serializes it MSB-first behind a sync header at a programmable bit rate.
- Sits between the packet sources and the serial line driver.

---
 rtl/fec_tx_sched_if.sv | 19 +
 rtl/fec_tx_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fec_tx_sched_if.sv
// rtl/fec_tx_sched_if.sv - two-source valid/ready word request bundle
interface fec_tx_sched_if;
  logic        req0_valid;
  logic [47:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [47:0] req1_data;
  logic        req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/fec_tx_sched.sv
// rtl/fec_tx_sched.sv - round-robin FEC word scheduler and sync-framed serializer
module fec_tx_sched #(
  parameter int         BIT_PERIOD = 4,
  parameter logic [7:0] SYNC_WORD  = 8'hE4,
  parameter int         GAP_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fec_tx_sched_if.slave        req,
  output logic [47:0]          fec_data,
  input  logic [95:0]          fec_code,
  output logic                 tx_bit,
  output logic                 tx_strobe,
  output logic                 tx_sof,
  output logic                 tx_eof,
  output logic                 tx_busy,
  output logic                 grant_id
);

  localparam int             PW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [PW-1:0]  PER_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [6:0]     GAP_LAST = 7'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, SYNC, CODE, GAP} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pc_q, pc_d;
  logic [6:0]     bit_q, bit_d;
  logic [103:0]   frame_q, frame_d;
  logic [47:0]    fec_data_q, fec_data_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_id_q, grant_id_d;
  logic           tx_bit_q, tx_bit_d;
  logic           tx_strobe_q, tx_strobe_d;
  logic           tx_sof_q, tx_sof_d;
  logic           tx_eof_q, tx_eof_d;
  logic           tx_busy_q, tx_busy_d;

  logic grant0, grant1, hs0, hs1, pc_wrap;

  // Round-robin pick: a lone requester wins, a tie goes away from the last winner
  always_comb begin
    grant0 = req.req0_valid & (~req.req1_valid | last_grant_q);
    grant1 = req.req1_valid & (~req.req0_valid | ~last_grant_q);
  end

  assign req.req0_ready = reset_n & (state_q == IDLE) & grant0;
  assign req.req1_ready = reset_n & (state_q == IDLE) & grant1;
  assign hs0 = req.req0_valid & req.req0_ready;
  assign hs1 = req.req1_valid & req.req1_ready;
  assign pc_wrap = (pc_q == PER_LAST);

  // Next-state: sync header and codeword share one 104-bit shift register, MSB out first
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    fec_data_d   = fec_data_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_bit_d     = tx_bit_q;
    tx_strobe_d  = 1'b0;
    tx_sof_d     = 1'b0;
    tx_eof_d     = 1'b0;
    tx_busy_d    = tx_busy_q;
    case (state_q)
      IDLE: begin
        if (hs0 | hs1) begin
          fec_data_d   = hs1 ? req.req1_data : req.req0_data;
          grant_id_d   = hs1;
          last_grant_d = hs1;
          tx_busy_d    = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        tx_bit_d    = SYNC_WORD[7];
        frame_d     = {SYNC_WORD[6:0], fec_code, 1'b0};
        tx_strobe_d = 1'b1;
        tx_sof_d    = 1'b1;
        pc_d        = '0;
        bit_d       = '0;
        state_d     = SYNC;
      end
      SYNC, CODE: begin
        if (!pc_wrap) begin
          pc_d = pc_q + 1'b1;
        end else if (state_q == CODE && bit_q == 7'd95) begin
          pc_d     = '0;
          bit_d    = '0;
          tx_bit_d = 1'b0;
          if (GAP_BITS == 0) begin
            tx_busy_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = GAP;
          end
        end else begin
          pc_d        = '0;
          tx_strobe_d = 1'b1;
          tx_bit_d    = frame_q[103];
          frame_d     = {frame_q[102:0], 1'b0};
          tx_eof_d    = (state_q == CODE) && (bit_q == 7'd94);
          if (state_q == SYNC && bit_q == 7'd7) begin
            bit_d   = '0;
            state_d = CODE;
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end
      end
      GAP: begin
        if (!pc_wrap) begin
          pc_d = pc_q + 1'b1;
        end else begin
          pc_d = '0;
          if (bit_q == GAP_LAST) begin
            tx_busy_d = 1'b0;
            state_d   = IDLE;
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      bit_q        <= '0;
      frame_q      <= '0;
      fec_data_q   <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      tx_bit_q     <= 1'b0;
      tx_strobe_q  <= 1'b0;
      tx_sof_q     <= 1'b0;
      tx_eof_q     <= 1'b0;
      tx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      fec_data_q   <= fec_data_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_bit_q     <= tx_bit_d;
      tx_strobe_q  <= tx_strobe_d;
      tx_sof_q     <= tx_sof_d;
      tx_eof_q     <= tx_eof_d;
      tx_busy_q    <= tx_busy_d;
    end
  end

  assign fec_data  = fec_data_q;
  assign grant_id  = grant_id_q;
  assign tx_bit    = tx_bit_q;
  assign tx_strobe = tx_strobe_q;
  assign tx_sof    = tx_sof_q;
  assign tx_eof    = tx_eof_q;
  assign tx_busy   = tx_busy_q;

endmodule
